ifid_fetch_stage: RTL and testbench
===================================

Name: ifid_fetch_stage

Overview:
Fetch stage plus IF/ID pipeline register feeding the ID/EX register of the 5-stage RV64 pipeline. It owns the PC and drives the instruction-memory address. It captures the fetched word with its PC into IF/ID and pre-extracts the rs1/rs2/rd/funct3 fields. It also contains load-use hazard detection against ID/EX and applies stall and branch-redirect flush.

Parameters:
XLEN, 64, PC and address width
RESET_PC, 64'h0, PC value loaded on reset
NOP_INSTR, 32'h00000013, word inserted on flush/reset (addi x0,x0,0)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
imem_addr  output  XLEN  instruction address (= PC register)
imem_rdata  input  32  instruction word, combinational read of imem_addr
pc_src  input  1  branch/jump taken, redirect request from EX/MEM
branch_target  input  XLEN  redirect target
ext_stall  input  1  external freeze (memory not ready)
idexmemread  input  1  ID/EX instruction is a load
idexrd  input  5  ID/EX destination register
ifidpc_out  output  XLEN  PC of instruction in IF/ID
ifidinstr  output  32  instruction in IF/ID
ifidvalid  output  1  IF/ID holds a real instruction
ifidrs1, ifidrs2, ifidrd  output  5  instr[19:15], [24:20], [11:7]
ifidfunct3  output  4  {instr[30], instr[14:12]}
hazard_stall  output  1  load-use bubble request; decode zeroes ID/EX controls
fetch_count  output  32  number of valid instructions captured into IF/ID

Behaviour:
- Reset (reset==0, asynchronous): PC=RESET_PC; ifidpc_out=0; ifidinstr=NOP_INSTR; ifidvalid=0; fetch_count=0. hazard_stall evaluates to 0, since ifidvalid=0.
- Reset asserted mid-operation discards all in-flight state immediately. The first edge after release captures imem_rdata at RESET_PC.
- imem_addr = PC combinationally; one-word fetch per cycle, zero-latency memory.
- load_use = idexmemread & (idexrd!=0) & ifidvalid & (idexrd==ifidrs1 | idexrd==ifidrs2). No decoding of whether rs2 is used; a conservative stall is acceptable.
- hazard_stall = load_use (combinational). stall = load_use | ext_stall.
- Priority at each rising edge: redirect > stall > advance.
  - Redirect (pc_src=1): PC <= {branch_target[XLEN-1:2],2'b00}. IF/ID flushed: ifidinstr=NOP_INSTR, ifidvalid=0, ifidpc_out=0. Applies even when stall is active in the same cycle. fetch_count unchanged.
  - Stall (pc_src=0): PC and all IF/ID outputs hold; fetch_count unchanged.
  - Advance: PC <= PC+4 (mod 2^XLEN, wraps silently). IF/ID <= {PC, imem_rdata, valid=1}. fetch_count += 1, wrapping at 2^32.
- Field outputs are slices of the registered ifidinstr; a flushed slot yields rs1=rs2=rd=0, funct3=0.
- Load-use stall lasts exactly one cycle for a single dependent instruction: the next edge moves the load out of ID/EX and decode inserts the bubble.
- Branch targets with bits [1:0]!=0 are force-aligned; no exception is raised.

Decomposition:
- Shared package rv_pipe_pkg holds NOP_INSTR, instruction field bit positions (RS1_LSB=15, RS2_LSB=20, RD_LSB=7, F3_LSB=12, F7B5=30), XLEN and RESET_PC defaults. ID/EX and EX/MEM stages use the same package.
- One sub-module, load_use_detect: purely combinational comparator producing load_use. It is reused by the future forwarding unit tests.

Test Plan:
- Reset then release, imem returns 0x00500093 at 0: first edge gives ifidpc_out=0, ifidinstr=0x00500093, ifidvalid=1, ifidrd=1, imem_addr=4, fetch_count=1.
- Straight line, 4 cycles: imem_addr = 0,4,8,12,16. ifidpc_out lags imem_addr by one cycle. fetch_count=4.
- Load-use: idexmemread=1, idexrd=5, IF/ID holds add x6,x5,x7 → hazard_stall=1; PC and IF/ID hold one edge. With idexrd=0 → no stall.
- Redirect: pc_src=1, branch_target=0x103 → next PC=0x100, ifidinstr=0x13, ifidvalid=0, hazard_stall=0 next cycle.
- Redirect with ext_stall=1 in the same cycle → redirect wins, PC=target, IF/ID flushed.
- Reset pulsed low between edges with PC=0x40 → outputs reach reset values immediately, without waiting for clk. PC wrap: RESET_PC=0xFFFF_FFFF_FFFF_FFFC advances to 0.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the RV64 pipeline stages: defaults, the NOP encoding
// and the instruction field bit positions.
package rv_pipe_pkg;

  localparam int unsigned XLEN_DEFAULT     = 64;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned F3_LSB  = 12;
  localparam int unsigned F7B5    = 30;

  typedef enum logic [1:0] {
    FETCH_ADVANCE,
    FETCH_STALL,
    FETCH_REDIRECT
  } fetch_act_e;

  // A redirect always beats a stall, so a taken branch can never be lost.
  function automatic fetch_act_e fetch_action(input logic redirect, input logic stall);
    if (redirect)   return FETCH_REDIRECT;
    else if (stall) return FETCH_STALL;
    else            return FETCH_ADVANCE;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: a load in ID/EX whose destination is read by
// the instruction in IF/ID.
module load_use_detect (
  input  logic       idex_memread,
  input  logic [4:0] idex_rd,
  input  logic       ifid_valid,
  input  logic [4:0] ifid_rs1,
  input  logic [4:0] ifid_rs2,
  output logic       load_use
);

  // rs2 is compared even for formats that do not read it; a spurious stall is harmless.
  assign load_use = idex_memread & (idex_rd != '0) & ifid_valid &
                    ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));

endmodule

// File: rtl/ifid_fetch_stage.sv
// Fetch stage with PC, IF/ID pipeline register, field pre-decode, load-use
// stall and branch-redirect flush.
module ifid_fetch_stage #(
  parameter int unsigned       XLEN      = rv_pipe_pkg::XLEN_DEFAULT,
  parameter logic [XLEN-1:0]   RESET_PC  = XLEN'(rv_pipe_pkg::RESET_PC_DEFAULT),
  parameter logic [31:0]       NOP_INSTR = rv_pipe_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            pc_src,
  input  logic [XLEN-1:0] branch_target,
  input  logic            ext_stall,
  input  logic            idexmemread,
  input  logic [4:0]      idexrd,
  output logic [XLEN-1:0] ifidpc_out,
  output logic [31:0]     ifidinstr,
  output logic            ifidvalid,
  output logic [4:0]      ifidrs1,
  output logic [4:0]      ifidrs2,
  output logic [4:0]      ifidrd,
  output logic [3:0]      ifidfunct3,
  output logic            hazard_stall,
  output logic [31:0]     fetch_count
);

  import rv_pipe_pkg::*;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [31:0]     fetch_count_q, fetch_count_d;
  logic            load_use;
  logic            stall;
  fetch_act_e      act;

  load_use_detect u_load_use_detect (
    .idex_memread (idexmemread),
    .idex_rd      (idexrd),
    .ifid_valid   (ifid_valid_q),
    .ifid_rs1     (ifidrs1),
    .ifid_rs2     (ifidrs2),
    .load_use     (load_use)
  );

  assign stall = load_use | ext_stall;
  assign act   = fetch_action(pc_src, stall);

  always_comb begin
    pc_d          = pc_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_valid_d  = ifid_valid_q;
    fetch_count_d = fetch_count_q;
    case (act)
      FETCH_REDIRECT: begin
        // Masking keeps the target word-aligned without trapping on bad bits.
        pc_d         = branch_target & ~XLEN'(3);
        ifid_pc_d    = '0;
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end
      FETCH_ADVANCE: begin
        pc_d          = pc_q + XLEN'(4);
        ifid_pc_d     = pc_q;
        ifid_instr_d  = imem_rdata;
        ifid_valid_d  = 1'b1;
        fetch_count_d = fetch_count_q + 32'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      ifid_pc_q     <= '0;
      ifid_instr_q  <= NOP_INSTR;
      ifid_valid_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_valid_q  <= ifid_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr    = pc_q;
  assign ifidpc_out   = ifid_pc_q;
  assign ifidinstr    = ifid_instr_q;
  assign ifidvalid    = ifid_valid_q;
  assign ifidrs1      = ifid_instr_q[RS1_LSB +: 5];
  assign ifidrs2      = ifid_instr_q[RS2_LSB +: 5];
  assign ifidrd       = ifid_instr_q[RD_LSB +: 5];
  assign ifidfunct3   = {ifid_instr_q[F7B5], ifid_instr_q[F3_LSB +: 3]};
  assign hazard_stall = load_use;
  assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_ifid_fetch_stage.sv
// Randomized bench for ifid_fetch_stage against a cycle-level reference model
// of the fetch/IF-ID rules, plus directed boundary scenarios.
module tb_ifid_fetch_stage;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [63:0] WRAP_PC  = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr, imem_addr2;
  logic [31:0] imem_rdata, imem_rdata2;
  logic        pc_src;
  logic [63:0] branch_target;
  logic        ext_stall;
  logic        idexmemread;
  logic [4:0]  idexrd;
  logic [63:0] ifidpc_out, ifidpc_out2;
  logic [31:0] ifidinstr, ifidinstr2;
  logic        ifidvalid, ifidvalid2;
  logic [4:0]  ifidrs1, ifidrs2, ifidrd, ifidrs1_2, ifidrs2_2, ifidrd_2;
  logic [3:0]  ifidfunct3, ifidfunct3_2;
  logic        hazard_stall, hazard_stall2;
  logic [31:0] fetch_count, fetch_count2;

  logic [31:0] mem [64];

  // Reference model state
  logic [63:0] ref_pc, ref_ifpc;
  logic [31:0] ref_instr, ref_cnt;
  logic        ref_valid;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  assign imem_rdata  = mem[imem_addr[7:2]];
  assign imem_rdata2 = mem[imem_addr2[7:2]];

  ifid_fetch_stage u_dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc_src(pc_src), .branch_target(branch_target), .ext_stall(ext_stall),
    .idexmemread(idexmemread), .idexrd(idexrd), .ifidpc_out(ifidpc_out),
    .ifidinstr(ifidinstr), .ifidvalid(ifidvalid), .ifidrs1(ifidrs1),
    .ifidrs2(ifidrs2), .ifidrd(ifidrd), .ifidfunct3(ifidfunct3),
    .hazard_stall(hazard_stall), .fetch_count(fetch_count)
  );

  ifid_fetch_stage #(.RESET_PC(WRAP_PC)) u_wrap (
    .clk(clk), .reset(reset), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .pc_src(pc_src), .branch_target(branch_target), .ext_stall(ext_stall),
    .idexmemread(idexmemread), .idexrd(idexrd), .ifidpc_out(ifidpc_out2),
    .ifidinstr(ifidinstr2), .ifidvalid(ifidvalid2), .ifidrs1(ifidrs1_2),
    .ifidrs2(ifidrs2_2), .ifidrd(ifidrd_2), .ifidfunct3(ifidfunct3_2),
    .hazard_stall(hazard_stall2), .fetch_count(fetch_count2)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_load_use();
    return idexmemread && (idexrd != 5'd0) && ref_valid &&
           ((idexrd == ref_instr[19:15]) || (idexrd == ref_instr[24:20]));
  endfunction

  task automatic model_reset();
    ref_pc    = 64'h0;
    ref_ifpc  = 64'h0;
    ref_instr = NOP;
    ref_valid = 1'b0;
    ref_cnt   = 32'd0;
  endtask

  task automatic check_all();
    check_eq("imem_addr",  imem_addr,    ref_pc);
    check_eq("ifidpc_out", ifidpc_out,   ref_ifpc);
    check_eq("ifidinstr",  ifidinstr,    ref_instr);
    check_eq("ifidvalid",  ifidvalid,    ref_valid);
    check_eq("ifidrs1",    ifidrs1,      ref_instr[19:15]);
    check_eq("ifidrs2",    ifidrs2,      ref_instr[24:20]);
    check_eq("ifidrd",     ifidrd,       ref_instr[11:7]);
    check_eq("ifidfunct3", ifidfunct3,   {ref_instr[30], ref_instr[14:12]});
    check_eq("hazard",     hazard_stall, exp_load_use());
    check_eq("fetch_cnt",  fetch_count,  ref_cnt);
  endtask

  // Entered and left at a falling edge; one rising edge in between.
  task automatic cycle(input logic ps, input logic [63:0] bt, input logic es,
                       input logic mr, input logic [4:0] rd);
    logic lu;
    pc_src = ps; branch_target = bt; ext_stall = es;
    idexmemread = mr; idexrd = rd;
    #1;
    check_all();
    lu = exp_load_use();
    @(posedge clk);
    if (ps) begin
      ref_pc    = {bt[63:2], 2'b00};
      ref_ifpc  = 64'h0;
      ref_instr = NOP;
      ref_valid = 1'b0;
    end else if (!(lu || es)) begin
      ref_ifpc  = ref_pc;
      ref_instr = mem[ref_pc[7:2]];
      ref_valid = 1'b1;
      ref_pc    = ref_pc + 64'd4;
      ref_cnt   = ref_cnt + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic rand_cycle();
    logic [4:0]  rd;
    logic [63:0] bt;
    case ($urandom_range(0, 3))
      0:       rd = ref_instr[19:15];
      1:       rd = ref_instr[24:20];
      default: rd = 5'($urandom);
    endcase
    bt = {32'($urandom), 32'($urandom)};
    cycle($urandom_range(0, 7) == 0, bt, $urandom_range(0, 3) == 0,
          1'($urandom), rd);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h0050_0093;   // addi x1,x0,5
    mem[1] = 32'h0072_8333;   // add  x6,x5,x7

    reset = 1'b0; pc_src = 1'b0; branch_target = '0; ext_stall = 1'b0;
    idexmemread = 1'b0; idexrd = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    check_eq("wrap_reset_addr", imem_addr2, WRAP_PC);
    reset = 1'b1;

    cycle(0, '0, 0, 0, 5'd0);
    check_eq("first_instr", ifidinstr, 32'h0050_0093);
    check_eq("first_rd",    ifidrd,    5'd1);
    check_eq("first_addr",  imem_addr, 64'd4);
    check_eq("first_cnt",   fetch_count, 32'd1);
    check_eq("wrap_addr",   imem_addr2, 64'd0);
    check_eq("wrap_ifpc",   ifidpc_out2, WRAP_PC);

    cycle(0, '0, 0, 0, 5'd0);
    idexmemread = 1'b1; idexrd = 5'd5;
    #1 check_eq("lu_hazard", hazard_stall, 1'b1);
    cycle(0, '0, 0, 1, 5'd5);
    check_eq("lu_hold_pc", imem_addr, 64'd8);
    idexmemread = 1'b1; idexrd = 5'd0;
    #1 check_eq("lu_x0_nostall", hazard_stall, 1'b0);
    cycle(0, '0, 0, 1, 5'd0);
    cycle(0, '0, 0, 0, 5'd0);
    check_eq("line_addr", imem_addr, 64'd16);
    check_eq("line_cnt",  fetch_count, 32'd4);

    cycle(1, 64'h103, 0, 0, 5'd0);
    idexmemread = 1'b1; idexrd = 5'd0;
    #1;
    check_eq("redir_pc",     imem_addr, 64'h100);
    check_eq("redir_instr",  ifidinstr, NOP);
    check_eq("redir_valid",  ifidvalid, 1'b0);
    check_eq("redir_hazard", hazard_stall, 1'b0);
    cycle(0, '0, 0, 0, 5'd0);
    cycle(1, 64'h20A, 1, 0, 5'd0);
    check_eq("redir_stall_pc",    imem_addr, 64'h208);
    check_eq("redir_stall_valid", ifidvalid, 1'b0);

    for (int n = 0; n < 400; n++) rand_cycle();

    cycle(1, 64'h40, 0, 0, 5'd0);
    cycle(0, '0, 0, 0, 5'd0);
    pc_src = 1'b0; ext_stall = 1'b0; idexmemread = 1'b0; idexrd = '0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    check_eq("async_addr", imem_addr, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 60; n++) rand_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
